// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/response sequencer in front of a combinational DATA_W-bit ALU.
// Optional completed-operation counter on op_count_o when ALU_SEQ_STATS_EN is defined.
//
// state | meaning
// IDLE  | no operation in flight; pops the FIFO head when one is present
// ISSUE | ALU operands applied; result captured at the end of this cycle
// RESP  | result presented on res_*; waits for res_ready_i
module alu_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [2:0]        cmd_op_i,
   input  logic [DATA_W-1:0] cmd_a_i,
   input  logic [DATA_W-1:0] cmd_b_i,
   input  logic              cmd_acc_i,
   output logic [DATA_W-1:0] alu_a_o,
   output logic [DATA_W-1:0] alu_b_o,
   output logic [2:0]        alu_opcode_o,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [DATA_W-1:0] res_data_o,
   output logic [DATA_W-1:0] acc_o,
   output logic              busy_o,
   output logic [15:0]       op_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 1 + 3 + 2 * DATA_W;
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]        state;
   logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr;
   logic              fifo_empty, fifo_full;
   logic              push, pop;
   logic [ENT_W-1:0]  head;
   logic              head_acc;
   logic [2:0]        head_op;
   logic [DATA_W-1:0] head_a, head_b, issue_a;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign cmd_ready_o = rst_ni && !fifo_full && !flush_i;
   assign push        = cmd_valid_i && cmd_ready_o;
   assign pop         = !flush_i && !fifo_empty &&
                        ((state == IDLE) || (state == RESP && res_valid_o && res_ready_i));

   assign head     = fifo_mem[rd_ptr[PTR_W-1:0]];
   assign head_acc = head[ENT_W-1];
   assign head_op  = head[2*DATA_W+2:2*DATA_W];
   assign head_a   = head[2*DATA_W-1:DATA_W];
   assign head_b   = head[DATA_W-1:0];
   assign issue_a  = head_acc ? acc_o : head_a;

   assign busy_o = !fifo_empty || (state != IDLE);

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_acc_i, cmd_op_i, cmd_a_i, cmd_b_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // The accumulator is written in ISSUE and read at pop, so a chained command
   // always picks up the result of the one before it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         alu_a_o      <= '0;
         alu_b_o      <= '0;
         alu_opcode_o <= '0;
         res_valid_o  <= 1'b0;
         res_data_o   <= '0;
         acc_o        <= '0;
      end else if (flush_i) begin
         state       <= IDLE;
         res_valid_o <= 1'b0;
         acc_o       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  alu_a_o      <= issue_a;
                  alu_b_o      <= head_b;
                  alu_opcode_o <= head_op;
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               res_data_o  <= alu_result_i;
               acc_o       <= alu_result_i;
               res_valid_o <= 1'b1;
               state       <= RESP;
            end
            RESP: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  if (pop) begin
                     alu_a_o      <= issue_a;
                     alu_b_o      <= head_b;
                     alu_opcode_o <= head_op;
                     state        <= ISSUE;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_SEQ_STATS_EN
   logic [15:0] op_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_count <= '0;
      end else if (flush_i) begin
         op_count <= '0;
      end else if (res_valid_o && res_ready_i && (op_count != 16'hFFFF)) begin
         op_count <= op_count + 16'd1;
      end
   end

   assign op_count_o = op_count;
`else
   assign op_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU and reference model.
// Expected op_count_o follows ALU_SEQ_STATS_EN, matching how the design is built.
module tb_alu_cmd_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       flush_i = 1'b0;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [2:0] cmd_op_i = '0;
   logic [7:0] cmd_a_i = '0;
   logic [7:0] cmd_b_i = '0;
   logic       cmd_acc_i = 1'b0;
   logic [7:0] alu_a_o, alu_b_o;
   logic [2:0] alu_opcode_o;
   logic [7:0] alu_result_i;
   logic       res_valid_o;
   logic       res_ready_i = 1'b0;
   logic [7:0] res_data_o, acc_o;
   logic       busy_o;
   logic [15:0] op_count_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  acc_m = '0;
   logic [15:0] stat_cnt = '0;
   logic        rnd_done;

   alu_cmd_sequencer #(.FIFO_DEPTH(4), .DATA_W(8)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_acc_i(cmd_acc_i),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
      .alu_result_i(alu_result_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .acc_o(acc_o), .busy_o(busy_o), .op_count_o(op_count_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[2:0];
         3'd6:    return a >> b[2:0];
         default: return ~a;
      endcase
   endfunction

   assign alu_result_i = alu_f(alu_opcode_o, alu_a_o, alu_b_o);

   function automatic logic [15:0] exp_count();
`ifdef ALU_SEQ_STATS_EN
      return stat_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
      int waited = 0;
      logic [7:0] r;
      cmd_valid_i = 1'b1;
      cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_acc_i = acc;
      @(negedge clk_i);
      while (!cmd_ready_o && waited < 100) begin
         @(negedge clk_i);
         waited++;
      end
      if (!cmd_ready_o) begin
         check("push_timeout", 32'(cmd_ready_o), 32'd1);
      end else begin
         r = alu_f(op, acc ? acc_m : a, b);
         acc_m = r;
         exp_q.push_back(r);
      end
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while ((busy_o || res_valid_o) && c < budget) begin
         tick(1);
         c++;
      end
      check("idle_timeout", 32'(busy_o), 32'd0);
   endtask

   task automatic model_clear();
      exp_q.delete();
      acc_m = '0;
      stat_cnt = '0;
   endtask

   // Monitor: every result handshake pops the oldest expected value.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk_i);
         if (rst_ni && res_valid_o && res_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_result: got %0h expected none at %0t", res_data_o, $time);
            end else begin
               e = exp_q.pop_front();
               check("result", 32'(res_data_o), 32'(e));
               check("acc_at_result", 32'(acc_o), 32'(e));
            end
            if (stat_cnt != 16'hFFFF) stat_cnt = stat_cnt + 16'd1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] hold_a, hold_b;
      logic [2:0] hold_op;
      rnd_done = 1'b0;

      // reset
      #12;
      check("rst_res_valid", 32'(res_valid_o), 32'd0);
      check("rst_acc", 32'(acc_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick(1);
      check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_op_count", 32'(op_count_o), 32'd0);

      // single add with latency check
      res_ready_i = 1'b1;
      push(3'd0, 8'h12, 8'h34, 1'b0);
      tick(1);
      check("add_opcode", 32'(alu_opcode_o), 32'd0);
      check("add_alu_a", 32'(alu_a_o), 32'h12);
      check("add_alu_b", 32'(alu_b_o), 32'h34);
      check("add_valid_early", 32'(res_valid_o), 32'd0);
      tick(1);
      check("add_valid", 32'(res_valid_o), 32'd1);
      check("add_data", 32'(res_data_o), 32'h46);
      check("add_acc", 32'(acc_o), 32'h46);
      wait_idle(20);

      // accumulator chain
      push(3'd0, 8'h05, 8'h03, 1'b0);
      push(3'd1, 8'hEE, 8'h02, 1'b1);
      for (int c = 0; c < 20 && alu_opcode_o != 3'd1; c++) tick(1);
      check("chain_opcode", 32'(alu_opcode_o), 32'd1);
      check("chain_alu_a", 32'(alu_a_o), 32'h08);
      wait_idle(20);
      check("chain_acc", 32'(acc_o), 32'h06);

      // backpressure, full FIFO, in-order drain at one result per two cycles
      res_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) push(3'd2, 8'hF0, 8'h3C + 8'(i), 1'b0);
      check("bp_ready_full", 32'(cmd_ready_o), 32'd0);
      check("bp_valid", 32'(res_valid_o), 32'd1);
      check("bp_data", 32'(res_data_o), 32'h30);
      tick(5);
      check("bp_hold_valid", 32'(res_valid_o), 32'd1);
      check("bp_hold_data", 32'(res_data_o), 32'h30);
      check("bp_hold_ready", 32'(cmd_ready_o), 32'd0);
      res_ready_i = 1'b1;
      tick(8);
      check("drain_busy_8", 32'(busy_o), 32'd1);
      tick(1);
      check("drain_busy_9", 32'(busy_o), 32'd0);
      check("stats_after_drain", 32'(op_count_o), 32'(exp_count()));

      // flush in RESP with two entries queued
      res_ready_i = 1'b0;
      push(3'd0, 8'h11, 8'h22, 1'b0);
      push(3'd4, 8'h33, 8'h0F, 1'b0);
      push(3'd3, 8'h40, 8'h01, 1'b0);
      check("fl_pre_valid", 32'(res_valid_o), 32'd1);
      hold_a = alu_a_o; hold_b = alu_b_o; hold_op = alu_opcode_o;
      flush_i = 1'b1;
      #1;
      check("fl_cmd_ready", 32'(cmd_ready_o), 32'd0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      model_clear();
      check("fl_valid", 32'(res_valid_o), 32'd0);
      check("fl_busy", 32'(busy_o), 32'd0);
      check("fl_acc", 32'(acc_o), 32'd0);
      check("fl_count", 32'(op_count_o), 32'd0);
      check("fl_alu_held", 32'({hold_op, hold_a, hold_b}), 32'({alu_opcode_o, alu_a_o, alu_b_o}) ^ 32'd0);
      res_ready_i = 1'b1;
      tick(6);
      check("fl_no_result", 32'(res_valid_o), 32'd0);
      check("fl_still_idle", 32'(busy_o), 32'd0);

      // stats: three handshakes then flush
      push(3'd0, 8'h01, 8'h01, 1'b0);
      push(3'd0, 8'h00, 8'h01, 1'b1);
      push(3'd5, 8'h00, 8'h02, 1'b1);
      wait_idle(30);
      check("stats_three", 32'(op_count_o), 32'(exp_count()));
      check("stats_acc", 32'(acc_o), 32'h0C);
      flush_i = 1'b1;
      tick(1);
      flush_i = 1'b0;
      model_clear();
      check("stats_flush", 32'(op_count_o), 32'd0);

      // randomized traffic with random result backpressure
      fork
         begin
            for (int n = 0; n < 150; n++) begin
               push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk_i);
               #1;
               res_ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      res_ready_i = 1'b1;
      wait_idle(200);
      check("rand_drained", 32'(exp_q.size()), 32'd0);
      check("rand_acc", 32'(acc_o), 32'(acc_m));
      check("rand_count", 32'(op_count_o), 32'(exp_count()));

      // asynchronous reset mid-operation
      res_ready_i = 1'b0;
      push(3'd4, 8'hA5, 8'h5A, 1'b0);
      push(3'd0, 8'h01, 8'h02, 1'b0);
      tick(1);
      check("mr_pre_valid", 32'(res_valid_o), 32'd1);
      #3;
      rst_ni = 1'b0;
      #1;
      model_clear();
      check("mr_valid", 32'(res_valid_o), 32'd0);
      check("mr_busy", 32'(busy_o), 32'd0);
      check("mr_acc", 32'(acc_o), 32'd0);
      check("mr_data", 32'(res_data_o), 32'd0);
      check("mr_alu", 32'({alu_opcode_o, alu_a_o, alu_b_o}), 32'd0);
      check("mr_count", 32'(op_count_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick(1);
      check("mr_ready", 32'(cmd_ready_o), 32'd1);
      tick(3);
      check("mr_stays_idle", 32'(busy_o), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
